led_pattern_indicator: RTL and testbench

Parametrised successor to the group-pattern LED decoder. It drives NUM_LEDS indicator LEDs. LED i lights when any of NUM_GROUPS input groups (GROUP_W bits each) equals pattern i. Inputs are synchronised and debounced, and the output stage offers direct, latched and blinking display modes.

---
 rtl/led_pattern_indicator.sv | 136 +++++++++++++
 tb/tb_led_pattern_indicator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_indicator.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_indicator
// Description : Lights LED i when any debounced input group equals pattern i;
//               direct, latched and blinking display modes.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_indicator #(
  parameter int                             GROUP_W    = 3,
  parameter int                             NUM_GROUPS = 2,
  parameter int                             NUM_LEDS   = 4,
  parameter logic [NUM_LEDS*GROUP_W-1:0]    PATTERNS   = {3'b101, 3'b111, 3'b000, 3'b010},
  parameter int                             DEBOUNCE   = 4,
  parameter int                             BLINK_HALF = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_GROUPS*GROUP_W-1:0]  groups_in,
  input  logic [1:0]                     mode,
  input  logic                           clear,
  output logic [NUM_LEDS-1:0]            leds,
  output logic                           update
);

  localparam int c_data_w = NUM_GROUPS * GROUP_W;
  localparam int c_dcnt_w = $clog2(DEBOUNCE + 1);
  localparam int c_bcnt_w = $clog2(BLINK_HALF + 1);
  localparam logic [c_dcnt_w-1:0] c_dcnt_max = c_dcnt_w'(DEBOUNCE - 1);
  localparam logic [c_bcnt_w-1:0] c_bcnt_max = c_bcnt_w'(BLINK_HALF - 1);

  logic [c_data_w-1:0] r_s1;
  logic [c_data_w-1:0] r_s2;
  logic [c_data_w-1:0] r_cand;
  logic [c_data_w-1:0] r_deb;
  logic                r_deb_valid;
  logic [c_dcnt_w-1:0] r_dcnt;
  logic                r_accept_q;
  logic [NUM_LEDS-1:0] r_latch;
  logic [NUM_LEDS-1:0] r_leds;
  logic                r_update;
  logic [c_bcnt_w-1:0] r_bcnt;
  logic                r_phase;

  logic                w_accept;
  logic [NUM_LEDS-1:0] w_hit;
  logic [NUM_LEDS-1:0] w_latch_next;
  logic [NUM_LEDS-1:0] w_leds_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= groups_in;
      r_s2 <= r_s1;
    end
  end

  // Accept only a value that has been stable long enough and differs from the
  // one already on display (or when nothing has been accepted yet).
  assign w_accept = (r_s2 == r_cand) && (r_dcnt == c_dcnt_max) &&
                    ((r_cand != r_deb) || !r_deb_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand      <= '0;
      r_deb       <= '0;
      r_deb_valid <= 1'b0;
      r_dcnt      <= '0;
      r_accept_q  <= 1'b0;
    end else begin
      r_accept_q <= w_accept;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_dcnt <= '0;
      end else if (r_dcnt < c_dcnt_max) begin
        r_dcnt <= r_dcnt + 1'b1;
      end else if (w_accept) begin
        r_deb       <= r_cand;
        r_deb_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (r_deb_valid && (r_deb[g*GROUP_W +: GROUP_W] == PATTERNS[i*GROUP_W +: GROUP_W])) begin
          w_hit[i] = 1'b1;
        end
      end
    end
  end

  assign w_latch_next = clear ? w_hit : (r_latch | w_hit);

  always_comb begin
    w_leds_next = w_hit;
    case (mode)
      2'd1:    w_leds_next = w_latch_next;
      2'd2:    w_leds_next = w_hit & {NUM_LEDS{r_phase}};
      default: w_leds_next = w_hit;
    endcase
  end

  // The blink timebase free-runs so the phase is independent of mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_bcnt == c_bcnt_max) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch  <= '0;
      r_leds   <= '0;
      r_update <= 1'b0;
    end else begin
      r_latch  <= w_latch_next;
      r_leds   <= w_leds_next;
      r_update <= r_accept_q;
    end
  end

  assign leds   = r_leds;
  assign update = r_update;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_indicator.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_indicator
// Description : Directed and randomised self-checking bench with a
//               run-length behavioural model of the LED pattern indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_indicator;

  localparam int          GW  = 3;
  localparam int          NG  = 2;
  localparam int          NL  = 4;
  localparam int          DB  = 4;
  localparam int          BH  = 8;
  localparam logic [11:0] PAT = {3'b101, 3'b111, 3'b000, 3'b010};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] groups_in = '0;
  logic [1:0] mode = '0;
  logic       clear = 1'b0;
  logic [3:0] leds;
  logic       update;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_pattern_indicator #(
    .GROUP_W    (GW),
    .NUM_GROUPS (NG),
    .NUM_LEDS   (NL),
    .PATTERNS   (PAT),
    .DEBOUNCE   (DB),
    .BLINK_HALF (BH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .groups_in (groups_in),
    .mode      (mode),
    .clear     (clear),
    .leds      (leds),
    .update    (update)
  );

  // Model state: the debouncer is a run length of identical synchronised
  // samples; the blink phase is derived from the cycle count since reset.
  typedef struct packed {
    logic [5:0]  x1;
    logic [5:0]  x2;
    logic [5:0]  last;
    logic [5:0]  deb;
    logic        dv;
    logic [3:0]  latch;
    logic [31:0] n;
    logic [31:0] run;
    logic [3:0]  leds;
    logic        upd;
    logic        acc;
  } mstate_t;

  mstate_t m;

  function automatic logic [3:0] model_hit(logic [5:0] d, logic v);
    logic [3:0]  h;
    logic [11:0] pats;
    h    = '0;
    pats = PAT;
    for (int i = 0; i < NL; i++)
      for (int g = 0; g < NG; g++)
        if (v && (d[g*GW +: GW] == pats[i*GW +: GW])) h[i] = 1'b1;
    return h;
  endfunction

  function automatic mstate_t reset_state();
    mstate_t r;
    r     = '0;
    r.run = 32'd1;
    return r;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [5:0] g, logic [1:0] md, logic clr);
    mstate_t    r;
    logic [5:0] x;
    logic [3:0] h;
    logic       ph;
    r    = s;
    x    = s.x2;
    r.x2 = s.x1;
    r.x1 = g;
    if (x == s.last) begin
      if (s.run < 32'd1000) r.run = s.run + 32'd1;
    end else begin
      r.run  = 32'd1;
      r.last = x;
    end
    h       = model_hit(s.deb, s.dv);
    r.latch = clr ? h : (s.latch | h);
    ph      = ((s.n / BH) % 2) == 0;
    case (md)
      2'd1:    r.leds = r.latch;
      2'd2:    r.leds = ph ? h : 4'b0000;
      default: r.leds = h;
    endcase
    r.upd = s.acc;
    r.acc = (r.run >= DB + 1) && ((r.last != s.deb) || !s.dv);
    if (r.acc) begin
      r.deb = r.last;
      r.dv  = 1'b1;
    end
    r.n = s.n + 32'd1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= reset_state();
    else     m <= step(m, groups_in, mode, clear);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("leds_vs_model", {28'd0, leds}, {28'd0, m.leds});
    chk("update_vs_model", {31'd0, update}, {31'd0, m.upd});
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic count_updates(input int k, output int c);
    c = 0;
    repeat (k) begin
      tick(1);
      if (update) c++;
    end
  endtask

  initial begin
    int c;
    int bad;
    int toggles;
    int other;
    logic prev;

    // 1: power-up with all-zero inputs
    tick(3);
    rst = 1'b0;
    tick(3);
    chk("t1_leds_early", {28'd0, leds}, 32'h0);
    count_updates(9, c);
    chk("t1_update_count", c, 1);
    chk("t1_leds", {28'd0, leds}, 32'b0010);

    // 2: two groups match two different patterns
    groups_in = 6'b111_010;
    count_updates(12, c);
    chk("t2_update_count", c, 1);
    chk("t2_leds", {28'd0, leds}, 32'b0101);

    // 3: short glitch is filtered
    groups_in = 6'b000_000;
    tick(2);
    groups_in = 6'b111_010;
    c = 0;
    bad = 0;
    repeat (14) begin
      tick(1);
      if (update) c++;
      if (leds != 4'b0101) bad++;
    end
    chk("t3_update_count", c, 0);
    chk("t3_leds_unstable", bad, 0);

    // 4: latch mode with clear
    mode = 2'd1;
    groups_in = 6'b000_010;
    tick(12);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    chk("t4_latch_a", {28'd0, leds}, 32'b0011);
    groups_in = 6'b000_101;
    tick(12);
    chk("t4_latch_b", {28'd0, leds}, 32'b1011);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t4_clear_hit", {28'd0, leds}, 32'b1010);
    groups_in = 6'b011_011;
    tick(12);
    chk("t4_latch_hold", {28'd0, leds}, 32'b1010);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t4_clear_nohit", {28'd0, leds}, 32'b0000);

    // 5: blink mode
    mode = 2'd2;
    groups_in = 6'b111_111;
    tick(12);
    prev = leds[2];
    toggles = 0;
    other = 0;
    repeat (32) begin
      tick(1);
      if (leds[2] != prev) toggles++;
      prev = leds[2];
      if ((leds & 4'b1011) != 4'b0000) other++;
    end
    chk("t5_toggles", toggles, 4);
    chk("t5_other_leds", other, 0);
    mode = 2'd0;
    tick(1);
    chk("t5_direct", {28'd0, leds}, 32'b0100);

    // 6: reset in the middle of a debounce
    groups_in = 6'b101_000;
    tick(3);
    rst = 1'b1;
    #1;
    chk("t6_rst_leds", {28'd0, leds}, 32'h0);
    chk("t6_rst_update", {31'd0, update}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("t6_leds_pending", {28'd0, leds}, 32'h0);
    count_updates(8, c);
    chk("t6_update_count", c, 1);
    chk("t6_leds", {28'd0, leds}, 32'b1010);

    // Randomised traffic checked against the model every cycle
    repeat (300) begin
      int hold;
      groups_in = 6'($urandom);
      mode      = 2'($urandom);
      hold      = $urandom_range(1, 12);
      repeat (hold) begin
        clear = ($urandom_range(0, 9) == 0);
        rst   = ($urandom_range(0, 499) == 0);
        tick(1);
      end
    end
    rst   = 1'b0;
    clear = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
